mod_n_counter: RTL
==================

// Module: mod_n_counter
// PURPOSE
//  Synchronous, fully clocked modulo-N counter that generalises the fixed mod-14 ripple counter.
//  Provides a parametrised width and a runtime-programmable modulus, plus up/down counting, synchronous load and enable.
//  Provides a terminal-count output for cascading stages and a wrap strobe.
//  Sits in timer/divider chains; tc of stage k drives en of stage k+1, with all stages on the same clk.
// PARAMETERS
//  WIDTH        4    counter width in bits (q range 0..2^WIDTH-1)
//  DEFAULT_MOD  14   modulus after reset; legal range 2..2^WIDTH
// PORTS
//  clk       in   1         single clock; all state updates on rising edge
//  rst       in   1         asynchronous, active-high reset
//  en        in   1         count enable
//  up_dn     in   1         1 = count up, 0 = count down
//  load      in   1         synchronous load strobe
//  load_val  in   WIDTH     value for load
//  mod_we    in   1         modulus write strobe
//  mod_val   in   WIDTH+1   new modulus
//  q         out  WIDTH     count value (registered)
//  mod_q     out  WIDTH+1   current modulus (registered)
//  tc        out  1         terminal count (combinational from registers + en/up_dn)
//  wrap      out  1         one-cycle pulse, registered: counter wrapped on previous edge
//  mod_err   out  1         one-cycle pulse, registered: illegal mod_val or load_val rejected
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: q=0, mod_q=DEFAULT_MOD, wrap=0, mod_err=0; applies immediately, mid-count included. First count is on the first edge after rst falls.
//  Per-edge priority: (1) modulus write, (2) load, (3) count.
//   The load and count steps use the modulus in effect after step 1 ("M").
//  Modulus write (mod_we=1):
//   - If 2 <= mod_val <= 2^WIDTH: mod_q <= mod_val.
//   - Otherwise: mod_q is unchanged and mod_err pulses.
//   - If the write is accepted, there is no load, and q >= the new M, then q <= 0. No wrap pulse.
//  Load (load=1):
//   - If load_val < M: q <= load_val.
//   - Otherwise: q <= 0 and mod_err pulses.
//   - Load ignores en and suppresses counting that cycle. wrap=0.
//  Count (en=1, no load):
//   - Up: q == M-1 -> q <= 0 and wrap pulses; else q+1.
//   - Down: q == 0 -> q <= M-1 and wrap pulses; else q-1.
//   - en=0: hold.
//  tc = en & (up_dn ? q==mod_q-1 : q==0), evaluated against the currently registered mod_q.
//   - Cascade rule: the next stage counts exactly on the edge where this stage wraps.
//  Latency: q, mod_q, wrap and mod_err update one edge after their inputs; tc has zero latency.
//  Width rules:
//   - Compare and arithmetic use WIDTH+1 bits; mod_q-1 always fits in WIDTH.
//   - With M = 2^WIDTH the counter is free-running binary and wraps at all-ones.
//  Direction change mid-count takes effect on the same edge; no state is lost.
//  Illegal states are unreachable. Any q >= mod_q can only arise from X and is cleared by reset.
// TESTING
//  1. Reset, en=1, up: q runs 0..13, then 0; wrap high on the cycle after the 13->0 edge; tc high while q=13.
//  2. Down with M=14: from 0, the next edge gives q=13 and wrap; tc high while q=0.
//  3. load=1, load_val=9, en=1 -> q=9 next cycle with no increment. load_val=15 with M=14 -> q=0 and mod_err pulse.
//  4. At q=11, write mod_val=10 -> mod_q=10 and q=0. Write mod_val=1 or 17 (WIDTH=4) -> mod_q unchanged and mod_err pulse.
//  5. Assert rst asynchronously (between edges) at q=7 -> q=0 and mod_q=14 immediately. Release -> counting resumes from 0.
//  6. Cascade two instances (M=14, M=5) via tc->en: 70 clk edges return both to 0; the second stage wraps once.

Source files
------------

// File: rtl/mod_n_counter.sv
// Synchronous modulo-N up/down counter with a runtime-programmable modulus, synchronous load,
// a combinational terminal count for cascading, and registered wrap/error strobes.
module mod_n_counter #(
   parameter int WIDTH       = 4,
   parameter int DEFAULT_MOD = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_we,
   input  logic [WIDTH:0]   mod_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH:0]   mod_q,
   output logic             tc,
   output logic             wrap,
   output logic             mod_err
);

   localparam logic [WIDTH:0]   MOD_RST = (WIDTH+1)'(DEFAULT_MOD);
   localparam logic [WIDTH:0]   MOD_MAX = (WIDTH+1)'(1) << WIDTH;
   localparam logic [WIDTH:0]   MOD_MIN = (WIDTH+1)'(2);
   localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   mod_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   logic             mod_ok;
   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   m_last;
   logic [WIDTH:0]   tc_last;

   // Modulus write resolves first; load and count both see the resulting modulus.
   always_comb begin
      mod_ok  = mod_we && (mod_val >= MOD_MIN) && (mod_val <= MOD_MAX);
      mod_d   = mod_ok ? mod_val : mod_q;
      m_last  = mod_d - ONE_X;
      cnt_ext = {1'b0, cnt_q};
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      err_d   = mod_we && !mod_ok;

      if (load) begin
         if ({1'b0, load_val} < mod_d) begin
            cnt_d = load_val;
         end else begin
            cnt_d = '0;
            err_d = 1'b1;
         end
      end else if (mod_ok && (cnt_ext >= mod_d)) begin
         // A shrinking modulus that strands the count out of range restarts it; no count this edge.
         cnt_d = '0;
      end else if (en) begin
         if (up_dn) begin
            if (cnt_ext == m_last) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE_Q;
            end
         end else begin
            if (cnt_q == '0) begin
               cnt_d  = m_last[WIDTH-1:0];
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE_Q;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         mod_q  <= MOD_RST;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mod_q  <= mod_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   // Terminal count looks at the registered modulus so a cascade stage steps on this stage's wrap edge.
   always_comb begin
      tc_last = mod_q - ONE_X;
      tc      = en && (up_dn ? ({1'b0, cnt_q} == tc_last) : (cnt_q == '0));
   end

   assign q       = cnt_q;
   assign wrap    = wrap_q;
   assign mod_err = err_q;

endmodule
